add_result_acc: RTL and testbench

Accumulator stage directly downstream of `full_adder_4b` in the 8-bit ALU datapath. It accepts the adder's 8-bit `result` words through a valid/ready handshake and sums a fixed batch of `N_SAMPLES` words into a wide register. It then presents the batch total with a sticky overflow flag on a second valid/ready handshake. This is the first clocked stage after the combinational adder and decouples it from the consumer.

---
 rtl/add_result_acc.sv | 97 +++++++++
 tb/tb_add_result_acc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/add_result_acc.sv
// Batch accumulator after full_adder_4b: sums N_SAMPLES result words, then holds the total for a handshake.
// Optional build macro ACC_SATURATE_EN clamps the total at 2^ACC_W-1 instead of wrapping.
module add_result_acc #(
   parameter int unsigned ACC_W     = 12,
   parameter int unsigned N_SAMPLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W:0]   sum;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sum     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, in_result};
      if (clear) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid) begin
`ifdef ACC_SATURATE_EN
                  // once clamped, any nonzero add carries again, so the clamp persists
                  acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                  acc_d = sum[ACC_W-1:0];
`endif
                  ovf_d = ovf_q | sum[ACC_W];
                  if (cnt_q == 4'(N_SAMPLES - 1)) begin
                     cnt_d   = '0;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
      // handshake flags are registered copies of the next state
      in_ready_d  = (state_d == ACCUM);
      out_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_result_acc.sv
// Directed bench for add_result_acc: default instance plus an ACC_W=9 instance for overflow.
module tb_add_result_acc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear, in_valid, out_ready;
   logic [7:0]  in_result;
   logic        in_ready, out_valid, out_ovf;
   logic [11:0] out_sum;

   logic        in_valid9;
   logic [7:0]  in_result9;
   logic        out_ready9;
   logic        in_ready9, out_valid9, out_ovf9;
   logic [8:0]  out_sum9;
   logic [31:0] exp_ovf_sum;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   add_result_acc u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf)
   );

   add_result_acc #(.ACC_W(9), .N_SAMPLES(4)) u_dut9 (
      .clk(clk), .rst_n(rst_n), .clear(1'b0),
      .in_valid(in_valid9), .in_ready(in_ready9), .in_result(in_result9),
      .out_valid(out_valid9), .out_ready(out_ready9),
      .out_sum(out_sum9), .out_ovf(out_ovf9)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [7:0] v);
      in_valid  = 1'b1;
      in_result = v;
      step();
      in_valid  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_result = '0; out_ready = 1'b1;
      in_valid9 = 1'b0; in_result9 = '0; out_ready9 = 1'b1;
      step(); step();
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_sum", out_sum, 0);
      check_eq("rst_out_ovf", out_ovf, 0);
      rst_n = 1'b1;
      step();

      // basic batch
      feed(8'd10); feed(8'd20); feed(8'd30);
      check_eq("basic_not_yet_valid", out_valid, 0);
      feed(8'd40);
      check_eq("basic_valid", out_valid, 1);
      check_eq("basic_sum", out_sum, 100);
      check_eq("basic_ovf", out_ovf, 0);
      check_eq("basic_in_ready_hold", in_ready, 0);
      step();
      check_eq("basic_valid_one_cycle", out_valid, 0);
      check_eq("basic_sum_cleared", out_sum, 0);
      check_eq("basic_in_ready_back", in_ready, 1);
      feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
      check_eq("batch2_sum", out_sum, 10);
      step();

      // backpressure
      out_ready = 1'b0;
      feed(8'd10); feed(8'd20); feed(8'd30); feed(8'd40);
      in_valid = 1'b1; in_result = 8'd99;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_sum", out_sum, 100);
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_valid", out_valid, 1);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check_eq("bp_released", out_valid, 0);
      feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
      check_eq("bp_no_99", out_sum, 10);
      step();

      // bubbles
      feed(8'd5); step(); feed(8'd6); step(); step(); feed(8'd7);
      check_eq("bubble_not_yet", out_valid, 0);
      feed(8'd8);
      check_eq("bubble_valid", out_valid, 1);
      check_eq("bubble_sum", out_sum, 26);
      step();

      // clear discards partial batch and the coincident input
      feed(8'd50); feed(8'd60);
      clear = 1'b1; in_valid = 1'b1; in_result = 8'd70;
      step();
      clear = 1'b0; in_valid = 1'b0;
      check_eq("clear_sum", out_sum, 0);
      feed(8'd1); feed(8'd2); feed(8'd3);
      check_eq("clear_cnt_reset", out_valid, 0);
      feed(8'd4);
      check_eq("clear_batch_sum", out_sum, 10);
      check_eq("clear_batch_valid", out_valid, 1);

      // clear coincident with output handshake
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_eq("clr_hs_valid", out_valid, 0);
      check_eq("clr_hs_sum", out_sum, 0);
      check_eq("clr_hs_in_ready", in_ready, 1);
      feed(8'd7); feed(8'd7); feed(8'd7); feed(8'd7);
      check_eq("clr_hs_next_sum", out_sum, 28);
      step();

      // overflow on the 9-bit instance
      for (int i = 0; i < 4; i++) begin
         in_valid9 = 1'b1; in_result9 = 8'd255;
         step();
      end
      in_valid9 = 1'b0;
`ifdef ACC_SATURATE_EN
      exp_ovf_sum = 511;
`else
      exp_ovf_sum = 508;
`endif
      check_eq("ovf_valid", out_valid9, 1);
      check_eq("ovf_sum", out_sum9, exp_ovf_sum);
      check_eq("ovf_flag", out_ovf9, 1);
      step();
      check_eq("ovf_flag_cleared", out_ovf9, 0);
      check_eq("ovf_sum_cleared", out_sum9, 0);
      in_valid9 = 1'b1; in_result9 = 8'd3;
      for (int i = 0; i < 4; i++) step();
      in_valid9 = 1'b0;
      check_eq("ovf_next_sum", out_sum9, 12);
      check_eq("ovf_next_flag", out_ovf9, 0);

      // async reset in HOLD
      out_ready = 1'b0;
      feed(8'd10); feed(8'd20); feed(8'd30); feed(8'd40);
      check_eq("ar_hold_sum", out_sum, 100);
      #2 rst_n = 1'b0;
      #1;
      check_eq("ar_valid", out_valid, 0);
      check_eq("ar_sum", out_sum, 0);
      check_eq("ar_in_ready", in_ready, 1);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      feed(8'd1); feed(8'd1); feed(8'd1); feed(8'd1);
      check_eq("ar_batch_sum", out_sum, 4);
      check_eq("ar_batch_valid", out_valid, 1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
